// File: rtl/rgen_host_if_apb.sv
// APB slave front end: turns each APB transfer into one register-block command and
// returns the response. Optional BUSY timeout is enabled by RGEN_HOST_IF_APB_TIMEOUT_EN.
module rgen_host_if_apb #(
  parameter int unsigned ADDRESS_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_psel,
  input  logic                     i_penable,
  input  logic                     i_pwrite,
  input  logic [ADDRESS_WIDTH-1:0] i_paddr,
  input  logic [DATA_WIDTH-1:0]    i_pwdata,
  output logic                     o_pready,
  output logic [DATA_WIDTH-1:0]    o_prdata,
  output logic                     o_pslverr,
  output logic                     o_command_valid,
  output logic                     o_write,
  output logic [ADDRESS_WIDTH-1:0] o_address,
  output logic [DATA_WIDTH-1:0]    o_write_data,
  input  logic                     i_response_ready,
  input  logic [DATA_WIDTH-1:0]    i_read_data,
  input  logic [1:0]               i_status
);

  localparam int unsigned AddrLsb = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDRESS_WIDTH-1:0] AddrMask = {ADDRESS_WIDTH{1'b1}} << AddrLsb;

  typedef enum logic [1:0] {StIdle, StBusy, StRespond} state_e;

  state_e state_q;

  // exokay has no APB equivalent
  logic unused_exokay;
  assign unused_exokay = i_status[1];

`ifdef RGEN_HOST_IF_APB_TIMEOUT_EN
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] timeout_cnt_q;
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      o_pready        <= 1'b0;
      o_prdata        <= '0;
      o_pslverr       <= 1'b0;
      o_command_valid <= 1'b0;
      o_write         <= 1'b0;
      o_address       <= '0;
      o_write_data    <= '0;
`ifdef RGEN_HOST_IF_APB_TIMEOUT_EN
      timeout_cnt_q   <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          // Only a proper setup phase starts a command.
          if (i_psel && !i_penable) begin
            o_write         <= i_pwrite;
            o_address       <= i_paddr & AddrMask;
            o_write_data    <= i_pwdata;
            o_command_valid <= 1'b1;
            state_q         <= StBusy;
`ifdef RGEN_HOST_IF_APB_TIMEOUT_EN
            timeout_cnt_q   <= '0;
`endif
          end
        end
        StBusy: begin
          // Valid must drop here or the response mux would fire the access again.
          if (i_response_ready) begin
            o_command_valid <= 1'b0;
            o_prdata        <= o_write ? '0 : i_read_data;
            o_pslverr       <= i_status[0];
            o_pready        <= i_psel;
            state_q         <= StRespond;
          end
`ifdef RGEN_HOST_IF_APB_TIMEOUT_EN
          else if (timeout_cnt_q == TimeoutLast) begin
            o_command_valid <= 1'b0;
            o_prdata        <= '0;
            o_pslverr       <= 1'b1;
            o_pready        <= i_psel;
            state_q         <= StRespond;
          end else begin
            timeout_cnt_q <= timeout_cnt_q + 16'd1;
          end
`endif
        end
        StRespond: begin
          o_pready  <= 1'b0;
          o_prdata  <= '0;
          o_pslverr <= 1'b0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
